// File: rtl/periph_bus_pkg.sv
// -----------------------------------------------------------------------------
// periph_bus_pkg
// Shared definitions for the CPU data-side peripheral bus controller:
//   - FSM state encoding of the transfer controller
//   - slave index map (RAM plus the memory-mapped peripherals)
//   - width of the wait-state / timeout counter
// Imported by periph_bus_decode and periph_bus_ctrl.
// -----------------------------------------------------------------------------
package periph_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_t;

    // Slave index map. Peripheral k sits at PERIPH_BASE window offset
    // addr[7:4] = k-1.
    localparam int SLV_RAM    = 0;
    localparam int SLV_LED    = 1;
    localparam int SLV_BUTTOM = 2;
    localparam int SLV_SWITCH = 3;
    localparam int SLV_TUBE   = 4;
    localparam int SLV_UART   = 5;
    localparam int SLV_TIMER  = 6;

    // Wide enough for the largest supported TIMEOUT (1023).
    localparam int CNT_W = 10;

endpackage

// File: rtl/periph_bus_decode.sv
// -----------------------------------------------------------------------------
// periph_bus_decode
// Combinational address decoder shared by the data-side and instruction-side
// bus controllers.
//   - top byte != PERIPH_BASE           -> slave 0 (RAM)
//   - top byte == PERIPH_BASE           -> slave addr[7:4]+1 if below N_SLV
//   - otherwise                         -> unmapped (valid = 0)
// Ports:
//   addr   in  ADDR_W  address to decode
//   valid  out 1       address maps onto an existing slave
//   index  out 4       decoded slave index (0 when unmapped)
//   onehot out N_SLV   one-hot select of the decoded slave (0 when unmapped)
// -----------------------------------------------------------------------------
module periph_bus_decode
    import periph_bus_pkg::*;
#(
    parameter int         ADDR_W      = 16,
    parameter int         N_SLV       = 8,
    parameter logic [7:0] PERIPH_BASE = 8'hFF
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic [3:0]        index,
    output logic [N_SLV-1:0]  onehot
);

    logic       in_window;
    logic [4:0] periph_idx;
    // Only the top byte and addr[7:4] take part in decoding.
    logic       addr_unused;

    assign addr_unused = ^addr;
    assign in_window   = (addr[ADDR_W-1 -: 8] == PERIPH_BASE);
    // One bit wider than the index so that nibble 15 + 1 does not wrap to 0.
    assign periph_idx  = {1'b0, addr[7:4]} + 5'd1;

    always_comb begin
        valid = 1'b0;
        index = 4'd0;
        if (!in_window) begin
            valid = 1'b1;
            index = 4'(SLV_RAM);
        end else if (periph_idx < 5'(N_SLV)) begin
            valid = 1'b1;
            index = periph_idx[3:0];
        end
    end

    always_comb begin
        onehot = '0;
        for (int k = 0; k < N_SLV; k++) begin
            onehot[k] = valid && (index == 4'(k));
        end
    end

endmodule

// File: rtl/periph_bus_ctrl.sv
// -----------------------------------------------------------------------------
// periph_bus_ctrl
// CPU data-side bus controller: decodes the load/store address onto RAM
// (slave 0) and the memory-mapped peripherals (LED, Buttom, Switch, Tube,
// UART, Timer), runs a registered req/ready handshake with wait states,
// a wait timeout with error response and an unmapped-address error.
//
// Optional feature macro: PERIPH_BUS_IRQ_EN
//   defined   : per-slave pending interrupt latched on s_irq rising edges,
//               cleared by a read of that slave; irq/irq_id registered.
//   undefined : irq = 0, irq_id = 0.
//
// Ports:
//   clk      in   1             system clock
//   rst      in   1             asynchronous reset, active-high
//   m_req    in   1             master request (sampled in IDLE only)
//   m_we     in   1             1 = write, 0 = read
//   m_addr   in   ADDR_W        master address
//   m_wdata  in   DATA_W        master write data
//   m_rdata  out  DATA_W        read data, valid while m_ready = 1
//   m_ready  out  1             one-cycle completion pulse
//   m_err    out  1             error flag, qualified by m_ready
//   s_sel    out  N_SLV         one-hot slave select, held through ACCESS
//   s_we     out  1             registered write enable
//   s_addr   out  ADDR_W        registered address
//   s_wdata  out  DATA_W        registered write data
//   s_rdata  in   N_SLV*DATA_W  packed slave read data (slave k at k*DATA_W)
//   s_ready  in   N_SLV         per-slave ready
//   s_irq    in   N_SLV         per-slave interrupt level
//   irq      out  1             aggregated interrupt
//   irq_id   out  4             lowest pending slave index
// -----------------------------------------------------------------------------
module periph_bus_ctrl
    import periph_bus_pkg::*;
#(
    parameter int         ADDR_W      = 16,
    parameter int         DATA_W      = 16,
    parameter int         N_SLV       = 8,
    parameter logic [7:0] PERIPH_BASE = 8'hFF,
    parameter int         TIMEOUT     = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_req,
    input  logic                    m_we,
    input  logic [ADDR_W-1:0]       m_addr,
    input  logic [DATA_W-1:0]       m_wdata,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    m_ready,
    output logic                    m_err,
    output logic [N_SLV-1:0]        s_sel,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [N_SLV*DATA_W-1:0] s_rdata,
    input  logic [N_SLV-1:0]        s_ready,
    input  logic [N_SLV-1:0]        s_irq,
    output logic                    irq,
    output logic [3:0]              irq_id
);

    bus_state_t        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [3:0]        sel_idx;

    logic              dec_valid;
    logic [3:0]        dec_idx;
    logic [N_SLV-1:0]  dec_onehot;

    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;

    // Decoding m_addr in IDLE is the same as decoding the latched address,
    // since the latch happens on the very edge the decision is taken.
    periph_bus_decode #(
        .ADDR_W      (ADDR_W),
        .N_SLV       (N_SLV),
        .PERIPH_BASE (PERIPH_BASE)
    ) u_decode (
        .addr   (m_addr),
        .valid  (dec_valid),
        .index  (dec_idx),
        .onehot (dec_onehot)
    );

    // Only the selected slave's ready and read data are ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (sel_idx == 4'(k)) begin
                sel_ready = s_ready[k];
                sel_rdata = s_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            sel_idx  <= '0;
            m_rdata  <= '0;
            m_ready  <= 1'b0;
            m_err    <= 1'b0;
            s_sel    <= '0;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
        end else begin
            m_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_req) begin
                        s_we    <= m_we;
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        sel_idx <= dec_idx;
                        if (dec_valid) begin
                            s_sel <= dec_onehot;
                            state <= ACCESS;
                        end else begin
                            m_rdata <= '0;
                            m_err   <= 1'b1;
                            m_ready <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end

                ACCESS: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // Ready is tested first so a late ready on the last
                    // allowed cycle still completes without error.
                    if (sel_ready) begin
                        m_rdata <= s_we ? '0 : sel_rdata;
                        m_err   <= 1'b0;
                        m_ready <= 1'b1;
                        s_sel   <= '0;
                        state   <= RESP;
                    end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        m_rdata <= '0;
                        m_err   <= 1'b1;
                        m_ready <= 1'b1;
                        s_sel   <= '0;
                        state   <= RESP;
                    end
                end

                RESP: begin
                    wait_cnt <= '0;
                    state    <= IDLE;
                end

                default: begin
                    wait_cnt <= '0;
                    s_sel    <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef PERIPH_BUS_IRQ_EN
    logic [N_SLV-1:0] s_irq_q;
    logic [N_SLV-1:0] pending;
    logic [N_SLV-1:0] irq_clr;
    logic [3:0]       lowest_pending;

    // A read that starts an access to a slave acknowledges its interrupt.
    assign irq_clr = (state == IDLE && m_req && dec_valid && !m_we) ? dec_onehot : '0;

    always_comb begin
        lowest_pending = 4'd0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if (pending[k]) begin
                lowest_pending = 4'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_irq_q <= '0;
            pending <= '0;
            irq     <= 1'b0;
            irq_id  <= 4'd0;
        end else begin
            s_irq_q <= s_irq;
            // OR-ing the new edges after the clear makes a set win.
            pending <= (pending & ~irq_clr) | (s_irq & ~s_irq_q);
            irq     <= |pending;
            irq_id  <= lowest_pending;
        end
    end
`else
    logic s_irq_unused;

    assign s_irq_unused = ^s_irq;
    assign irq          = 1'b0;
    assign irq_id       = 4'd0;
`endif

endmodule
